// File: rtl/axil_mmio_master_pkg.sv
// Shared types and constants for the AXI4-Lite MMIO master.
// The response decode lives here so the FSM and any checkers agree on what counts as an error.
package axil_mmio_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_mmio_master_if.sv
// AXI4-Lite bus bundle between the MMIO master and the SoC fabric.
// Every channel uses strict valid/ready: a beat transfers on the rising edge where both are high,
// and a source never withdraws valid before that edge (timeout and reset excepted).
interface axil_mmio_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_mmio_master_timeout_ctr.sv
// Down-counter that pulses expire_o in the enabled cycle where the count reaches zero.
// TIMEOUT_CYC=0 removes the counter and never expires.
module axil_mmio_master_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expire_o = 1'b0;
    end else begin : g_timeout
      logic [TO_W-1:0] cnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else if (load_i) begin
          cnt_q <= TO_W'(TIMEOUT_CYC);
        end else if (en_i && (cnt_q != '0)) begin
          cnt_q <= cnt_q - TO_W'(1);
        end
      end

      assign expire_o = en_i && (cnt_q == TO_W'(1));
    end
  endgenerate

endmodule

// File: rtl/axil_mmio_master.sv
// Single-outstanding AXI4-Lite master for the core's MMIO load/store port.
// All outputs come from flops; next values are decoded from next_state so nothing is combinational to the bus.
module axil_mmio_master
  import axil_mmio_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                resp_to_o,
  output logic                busy_o,
  output state_t              state_o,
  axil_mmio_master_if.master  m_axi
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, resp_rdata_q, cap_rdata;
  logic [STRB_W-1:0]   strb_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic req_ready_q, resp_valid_q, resp_err_q, resp_to_q, busy_q;
  logic accept, aw_done, w_done, timer_en, expire, to_hit, cap_err;

  assign accept   = (state_q == ST_IDLE) && req_ready_q && req_valid_i;
  assign aw_done  = !awvalid_q || m_axi.awready;
  assign w_done   = !wvalid_q || m_axi.wready;
  assign timer_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

  axil_mmio_master_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .en_i     (timer_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= next_state;
  end

  // A handshake that completes the current phase takes priority over an expiry in the same cycle.
  always_comb begin
    next_state = state_q;
    to_hit     = 1'b0;
    cap_err    = 1'b0;
    cap_rdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) next_state = req_we_i ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      end
      ST_WR_ADDR_DATA: begin
        if (aw_done && w_done) next_state = ST_WR_RESP;
        else if (expire) begin next_state = ST_RESP; to_hit = 1'b1; end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          next_state = ST_RESP;
          cap_err    = resp_is_err(m_axi.bresp);
        end else if (expire) begin next_state = ST_RESP; to_hit = 1'b1; end
      end
      ST_RD_ADDR: begin
        if (m_axi.arready) next_state = ST_RD_DATA;
        else if (expire) begin next_state = ST_RESP; to_hit = 1'b1; end
      end
      ST_RD_DATA: begin
        if (m_axi.rvalid) begin
          next_state = ST_RESP;
          cap_err    = resp_is_err(m_axi.rresp);
          cap_rdata  = cap_err ? '0 : m_axi.rdata;
        end else if (expire) begin next_state = ST_RESP; to_hit = 1'b1; end
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_to_q    <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        strb_q  <= req_be_i;
      end
      // AW and W each stay up until their own handshake, independently of the other.
      awvalid_q    <= (next_state == ST_WR_ADDR_DATA) &&
                      ((state_q == ST_IDLE) || (awvalid_q && !m_axi.awready));
      wvalid_q     <= (next_state == ST_WR_ADDR_DATA) &&
                      ((state_q == ST_IDLE) || (wvalid_q && !m_axi.wready));
      bready_q     <= (next_state == ST_WR_RESP);
      arvalid_q    <= (next_state == ST_RD_ADDR);
      rready_q     <= (next_state == ST_RD_DATA);
      req_ready_q  <= (next_state == ST_IDLE);
      busy_q       <= (next_state != ST_IDLE);
      resp_valid_q <= (next_state == ST_RESP);
      resp_err_q   <= (next_state == ST_RESP) && (cap_err || to_hit);
      resp_to_q    <= (next_state == ST_RESP) && to_hit;
      resp_rdata_q <= (next_state == ST_RESP) ? cap_rdata : '0;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_rdata_o  = resp_rdata_q;
  assign resp_err_o    = resp_err_q;
  assign resp_to_o     = resp_to_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule
